// File: rtl/serial_paralelo.sv
// serial_paralelo: receive-side deserializer for phy_rx.
// Shifts in the clk_32f serial stream MSB first and finds byte alignment by
// locking onto a run of N_BC comma bytes (IDLE). Once locked (active), each
// aligned non-idle byte is presented on data_out with valid_out high for
// one byte period. Idle bytes drop valid_out and leave data_out unchanged.
// Alignment is sticky: only reset_L returns the block to the search state.
module serial_paralelo #(
  parameter logic [7:0] IDLE = 8'hBC,
  parameter int         N_BC = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  // The comma run length is held in a 4-bit counter, so the legal range is 1..15.
  localparam logic [3:0] NBC = 4'(N_BC);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,  // sliding-window hunt for the first comma
    ALIGN  = 2'd1,  // comma seen, counting aligned commas
    ACTIVE = 2'd2   // locked, decoding aligned bytes
  } state_t;

  state_t     state, state_n;
  logic [7:0] sr, sr_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] bc_cnt, bc_cnt_n;
  logic [7:0] data_n;
  logic       valid_n;

  // Byte that completes on this edge: the last seven shifted bits plus the
  // bit being sampled now. Outputs are taken from this so they update on the
  // same edge as the byte's LSB.
  logic [7:0] nxt;
  logic       boundary;
  logic       is_idle;

  assign nxt      = {sr[6:0], data_in};
  assign is_idle  = (nxt == IDLE);
  // bit_cnt==7 means nxt is a complete byte on the locked grid. It is
  // meaningless in SEARCH, where every bit position is tried instead.
  assign boundary = (bit_cnt == 3'd7);

  // active is the state itself, so it rises on the edge that enters ACTIVE.
  assign active = (state == ACTIVE);

  // State, shift register, counters and output registers.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEARCH;
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      bc_cnt    <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      bit_cnt   <= bit_cnt_n;
      bc_cnt    <= bc_cnt_n;
      data_out  <= data_n;
      valid_out <= valid_n;
    end
  end

  // Next-state, alignment counting and byte decode.
  always_comb begin
    state_n   = state;
    sr_n      = nxt;
    bit_cnt_n = bit_cnt + 3'd1;
    bc_cnt_n  = bc_cnt;
    data_n    = data_out;
    valid_n   = valid_out;

    case (state)
      SEARCH: begin
        // bit_cnt has no meaning until a comma is found, so it is held.
        bit_cnt_n = bit_cnt;
        if (is_idle) begin
          // This edge closes a byte, so the grid restarts from here:
          // the next edge is bit 0 of the following byte.
          bit_cnt_n = 3'd0;
          bc_cnt_n  = 4'd1;
          state_n   = (NBC == 4'd1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        if (boundary) begin
          if (is_idle) begin
            if (bc_cnt + 4'd1 >= NBC) begin
              bc_cnt_n = NBC;  // saturate, never wrap
              state_n  = ACTIVE;
            end else begin
              bc_cnt_n = bc_cnt + 4'd1;
            end
          end else begin
            // Not a comma on the candidate grid: the first match was a
            // false alignment. Resume bit-sliding from the next edge.
            bc_cnt_n = 4'd0;
            state_n  = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // Outputs only change at byte boundaries, which keeps them stable
        // for exactly eight bit clocks. Off-grid commas are ignored.
        if (boundary) begin
          if (is_idle) begin
            valid_n = 1'b0;
          end else begin
            data_n  = nxt;
            valid_n = 1'b1;
          end
        end
      end

      default: begin
        state_n  = SEARCH;
        bc_cnt_n = 4'd0;
      end
    endcase
  end

endmodule
